// File: rtl/flop_cells.sv
// flop_cells: the storage primitives used by the reset controllers.
//   - WIDTH plain rising-edge D flops with synchronous reset
//   - WIDTH D flops with per-lane asynchronous active-high set
//   - a four-stage reset-stretch chain (two async-set stages, then two plain)
// Set always wins over reset and data. Synchronous reset clears every stage
// that is not being held by its set input.
module flop_cells #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] as_d,
   input  logic [WIDTH-1:0] as_set,
   output logic [WIDTH-1:0] as_q,
   input  logic             chain_set,
   output logic             chain_out
);

   // ------------------------------------------------------------------
   // Plain lanes
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] q_reg;

   // Plain D flops: reset clears, otherwise capture d.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= '0;
      end else begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

   // ------------------------------------------------------------------
   // Async-set lanes: each lane has its own set, so each gets its own
   // process with its own set event.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_as_lane
      logic lane_set;
      logic lane_q_reg;

      assign lane_set = as_set[gi];

      // Set forces 1 immediately and holds it; on a clock edge with set
      // low the flop resets or captures its data.
      always_ff @(posedge clk or posedge lane_set) begin
         if (lane_set) begin
            lane_q_reg <= 1'b1;
         end else if (reset) begin
            lane_q_reg <= 1'b0;
         end else begin
            lane_q_reg <= as_d[gi];
         end
      end

      assign as_q[gi] = lane_q_reg;
   end

   // ------------------------------------------------------------------
   // Reset-stretch chain. Stage 1 has D tied low, so once chain_set falls
   // it drains a single 1 through stages 2..4; stage 2 being set as well
   // guarantees the output stays high for at least two cycles even for a
   // sub-cycle set pulse.
   // ------------------------------------------------------------------
   logic s1_reg;
   logic s2_reg;
   logic s3_reg;
   logic s4_reg;

   // Stage 1: async set, D tied to 0.
   always_ff @(posedge clk or posedge chain_set) begin
      if (chain_set) begin
         s1_reg <= 1'b1;
      end else begin
         // Reset and data both yield 0 here.
         s1_reg <= 1'b0;
      end
   end

   // Stage 2: async set, D = stage 1.
   always_ff @(posedge clk or posedge chain_set) begin
      if (chain_set) begin
         s2_reg <= 1'b1;
      end else if (reset) begin
         s2_reg <= 1'b0;
      end else begin
         s2_reg <= s1_reg;
      end
   end

   // Stages 3 and 4: plain synchronous flops completing the stretch.
   always_ff @(posedge clk) begin
      if (reset) begin
         s3_reg <= 1'b0;
         s4_reg <= 1'b0;
      end else begin
         s3_reg <= s2_reg;
         s4_reg <= s3_reg;
      end
   end

   assign chain_out = s4_reg;

endmodule

// File: tb/tb_flop_cells.sv
// Testbench for flop_cells (WIDTH=4): table-driven vectors, directed chain
// sequences, and randomized stimulus against a behavioural model.
module tb_flop_cells;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic [W-1:0] as_d;
   logic [W-1:0] as_set;
   logic [W-1:0] as_q;
   logic         chain_set;
   logic         chain_out;

   int checks;
   int failures;

   flop_cells #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .d         (d),
      .q         (q),
      .as_d      (as_d),
      .as_set    (as_set),
      .as_q      (as_q),
      .chain_set (chain_set),
      .chain_out (chain_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic         rst;
      logic [W-1:0] dv;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_as;
      logic         exp_chain;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic a_prev1, a_prev2, a_cur, lvl_prev;
      logic exp_chain;
      logic [W-1:0] hold, pulse, exp_q, exp_as;
      logic r;
      int mode;
      logic chain_hold_exp[10];
      logic chain_half_exp[5];
      logic chain_rst_exp[5];

      checks = 0;
      failures = 0;
      reset = 1'b1;
      d = '0;
      as_d = '0;
      as_set = '0;
      chain_set = 1'b0;

      // ---------------- table-driven plain lanes + reset state ----------
      vecs[0] = '{1'b1, 4'hA, 4'h0, 4'h0, 1'b0};
      vecs[1] = '{1'b1, 4'hA, 4'h0, 4'h0, 1'b0};
      vecs[2] = '{1'b0, 4'hA, 4'hA, 4'h0, 1'b0};
      vecs[3] = '{1'b0, 4'h5, 4'h5, 4'h0, 1'b0};
      vecs[4] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
      vecs[5] = '{1'b0, 4'h3, 4'h3, 4'h0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         reset = vecs[i].rst;
         d = vecs[i].dv;
         tick();
         check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d_as_q", i), 32'(as_q), 32'(vecs[i].exp_as));
         check($sformatf("vec%0d_chain", i), 32'(chain_out), 32'(vecs[i].exp_chain));
         $display("vec %0d rst=%0b d=%h q=%h", i, vecs[i].rst, vecs[i].dv, q);
      end

      // ---------------- async set pulse on lane 1 ----------------------
      as_d = '0;
      #2 as_set = 4'b0010;
      #2 check("as_pulse_immediate", 32'(as_q), 32'h2);
      as_set = '0;
      #1 check("as_pulse_held", 32'(as_q), 32'h2);
      tick();
      check("as_pulse_cleared", 32'(as_q), 32'h0);
      $display("as_set pulse lane1 done as_q=%h", as_q);

      // ---------------- set held across reset --------------------------
      reset = 1'b1;
      as_set = 4'b0001;
      for (int e = 0; e < 3; e++) begin
         tick();
         check($sformatf("set_vs_reset_e%0d", e), 32'(as_q), 32'h1);
      end
      as_set = '0;
      #1 check("set_drop_before_edge", 32'(as_q), 32'h1);
      tick();
      check("set_drop_after_edge", 32'(as_q), 32'h0);
      reset = 1'b0;
      tick();
      $display("set vs reset sequence done as_q=%h", as_q);

      // ---------------- chain: half-cycle pulse ------------------------
      chain_half_exp = '{0, 0, 1, 1, 0};
      tick();
      check("chain_half_e0", 32'(chain_out), 32'(chain_half_exp[0]));
      #2 chain_set = 1'b1;
      #4 chain_set = 1'b0;
      for (int e = 1; e < 5; e++) begin
         tick();
         check($sformatf("chain_half_e%0d", e), 32'(chain_out), 32'(chain_half_exp[e]));
      end
      $display("chain half pulse done");
      repeat (3) tick();

      // ---------------- chain: held for 5 edges ------------------------
      chain_hold_exp = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      chain_set = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         if (e == 4) chain_set = 1'b0;
         check($sformatf("chain_hold_e%0d", e + 1), 32'(chain_out), 32'(chain_hold_exp[e]));
      end
      $display("chain held pulse done");

      // ---------------- chain: reset mid-pulse -------------------------
      chain_rst_exp = '{0, 1, 0, 0, 0};
      #2 chain_set = 1'b1;
      #4 chain_set = 1'b0;
      for (int e = 0; e < 5; e++) begin
         reset = (e == 2);
         tick();
         check($sformatf("chain_rst_e%0d", e + 1), 32'(chain_out), 32'(chain_rst_exp[e]));
      end
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("chain_rst_after", 32'(chain_out), 32'h0);
      end
      $display("chain reset mid-pulse done");

      // ---------------- random lanes -----------------------------------
      for (int n = 0; n < 200; n++) begin
         d = W'($urandom);
         as_d = W'($urandom);
         r = ($urandom_range(0, 7) == 0);
         reset = r;
         hold = W'($urandom) & W'($urandom) & W'($urandom);
         pulse = W'($urandom) & W'($urandom);
         #2 as_set = hold | pulse;
         #2 check("rand_as_immediate", 32'(as_q & (hold | pulse)), 32'(hold | pulse));
         as_set = hold;
         exp_q = r ? '0 : d;
         exp_as = hold | (r ? '0 : as_d);
         tick();
         check("rand_q", 32'(q), 32'(exp_q));
         check("rand_as_q", 32'(as_q), 32'(exp_as));
         $display("rand lane %0d rst=%0b d=%h q=%h as_d=%h set=%h as_q=%h", n, r, d, q, as_d, hold, as_q);
      end
      as_set = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // ---------------- random chain -----------------------------------
      // Model: chain_out after edge k is high iff chain_set was high at any
      // instant in either of the two intervals (edge k-3, edge k-2] or
      // (edge k-2, edge k-1].
      a_prev1 = 1'b0;
      a_prev2 = 1'b0;
      for (int n = 0; n < 300; n++) begin
         lvl_prev = chain_set;
         mode = $urandom_range(0, 5);
         if (mode == 0) begin
            #2 chain_set = 1'b1;
            #3 chain_set = 1'b0;
         end else if (mode == 1) begin
            chain_set = 1'b1;
         end else begin
            chain_set = 1'b0;
         end
         a_cur = lvl_prev | (mode <= 1);
         exp_chain = a_prev1 | a_prev2;
         tick();
         check("rand_chain", 32'(chain_out), 32'(exp_chain));
         $display("rand chain %0d mode=%0d out=%0b", n, mode, chain_out);
         a_prev2 = a_prev1;
         a_prev1 = a_cur;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
